// File: rtl/mem_arbiter.sv
// Shares one pipelined main memory between the I-cache and D-cache miss handlers:
// arbitrates, sequences 8-word block fills and single-word write-through stores.
// Define ARB_RR_EN for round-robin arbitration instead of fixed D-over-I priority.
module mem_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int WORDS_PER_BLK = 8,
  parameter int MEM_LAT       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_grant,
  output logic              ic_data_valid,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_grant,
  output logic              dc_data_valid,
  output logic              dc_done,
  output logic [2:0]        fill_word,
  output logic [DATA_W-1:0] fill_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  localparam int CNT_W          = $clog2(WORDS_PER_BLK);
  localparam int RET_W          = CNT_W + 1;
  localparam int BYTES_PER_WORD = DATA_W / 8;
  localparam int WORD_SH        = $clog2(BYTES_PER_WORD);
  localparam int OFF_W          = $clog2(WORDS_PER_BLK * BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(WORDS_PER_BLK - 1);
  localparam logic [RET_W-1:0] NUM_WORDS = RET_W'(WORDS_PER_BLK);
  // With zero latency the last return lands in the last issue cycle.
  localparam bit ZERO_LAT = (MEM_LAT == 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [RET_W-1:0]  ret_cnt_q, ret_cnt_d;

  logic              dc_wins;
  logic              take_ret;
  logic              last_ret;
  logic              busy;
  logic [ADDR_W-1:0] blk_base;
  logic [ADDR_W-1:0] word_off;

  assign busy     = (state_q != S_IDLE);
  assign take_ret = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) &&
                    mem_rvalid && (ret_cnt_q < NUM_WORDS);
  assign last_ret = take_ret && (ret_cnt_q == NUM_WORDS - 1'b1);
  assign blk_base = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign word_off = ADDR_W'(issue_cnt_q) << WORD_SH;

`ifdef ARB_RR_EN
  owner_e last_owner_q, last_owner_d;

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    if (dc_req && ic_req) dc_wins = (last_owner_q == OWN_I);
    else                  dc_wins = dc_req;
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == S_DONE) last_owner_d = owner_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_owner_q <= OWN_I;
    else     last_owner_q <= last_owner_d;
  end
`else
  // MEM stage is older than IF, so D always wins; I-cache may starve.
  assign dc_wins = dc_req;
`endif

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;

    if (take_ret) ret_cnt_d = ret_cnt_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (dc_req || ic_req) begin
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          if (dc_wins) begin
            owner_d = OWN_D;
            addr_d  = dc_addr;
            if (dc_we) begin
              wdata_d = dc_wdata;
              state_d = S_WRITE;
            end else begin
              state_d = S_ISSUE;
            end
          end else begin
            owner_d = OWN_I;
            addr_d  = ic_addr;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == LAST_IDX) state_d = (ZERO_LAT && last_ret) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: if (last_ret) state_d = S_DONE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_I;
      addr_q      <= '0;
      wdata_q     <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
    end
  end

  // Memory-side outputs depend only on registered state, never on the requests.
  always_comb begin
    ic_grant      = 1'b0;
    dc_grant      = 1'b0;
    ic_done       = 1'b0;
    dc_done       = 1'b0;
    ic_data_valid = 1'b0;
    dc_data_valid = 1'b0;
    fill_word     = '0;
    fill_data     = '0;
    mem_en        = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;

    ic_grant = busy && (owner_q == OWN_I);
    dc_grant = busy && (owner_q == OWN_D);
    ic_done  = (state_q == S_DONE) && (owner_q == OWN_I);
    dc_done  = (state_q == S_DONE) && (owner_q == OWN_D);

    ic_data_valid = take_ret && (owner_q == OWN_I);
    dc_data_valid = take_ret && (owner_q == OWN_D);
    if (take_ret) begin
      fill_word = 3'(ret_cnt_q[CNT_W-1:0]);
      fill_data = mem_rdata;
    end

    unique case (state_q)
      S_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = blk_base + word_off;
      end
      S_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level timing model compared every
// cycle, plus directed scenarios with hand-computed cycle/address/data expectations.
module tb_mem_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int WPB     = 8;
  localparam int MEM_LAT = 4;
  localparam int TIMEOUT = 200;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ic_req = 1'b0;
  logic [ADDR_W-1:0] ic_addr = '0;
  logic              dc_req = 1'b0;
  logic              dc_we = 1'b0;
  logic [ADDR_W-1:0] dc_addr = '0;
  logic [DATA_W-1:0] dc_wdata = '0;
  logic              ic_grant, ic_data_valid, ic_done;
  logic              dc_grant, dc_data_valid, dc_done;
  logic [2:0]        fill_word;
  logic [DATA_W-1:0] fill_data;
  logic              mem_en, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_BLK(WPB), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_grant(ic_grant),
    .ic_data_valid(ic_data_valid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_grant(dc_grant), .dc_data_valid(dc_data_valid), .dc_done(dc_done),
    .fill_word(fill_word), .fill_data(fill_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  bit  checking = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pipelined memory: a read accepted at an edge returns MEM_LAT cycles after issue;
  // each word's content equals its byte address. Not reset, so in-flight reads survive rst.
  logic [MEM_LAT-1:0] pipe_v = '0;
  logic [DATA_W-1:0]  pipe_d [MEM_LAT] = '{default: '0};
  always @(posedge clk) begin
    pipe_v    <= {pipe_v[MEM_LAT-2:0], mem_en & ~mem_wr};
    pipe_d[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) pipe_d[i] <= pipe_d[i-1];
  end
  assign mem_rvalid = pipe_v[MEM_LAT-1];
  assign mem_rdata  = pipe_d[MEM_LAT-1];

  // Transaction model: a transaction is (owner, kind, address) plus its age in cycles.
  bit          m_busy = 1'b0;
  bit          m_own_d = 1'b0;
  bit          m_write = 1'b0;
  bit          m_last_d = 1'b0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  int          m_age = 0;

  function automatic int txn_len();
    return m_write ? 2 : MEM_LAT + WPB + 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   = 1'b0;
      m_last_d = 1'b0;
      m_age    = 0;
    end else if (m_busy) begin
      if (m_age == txn_len() - 1) begin
        m_busy   = 1'b0;
        m_last_d = m_own_d;
      end else begin
        m_age++;
      end
    end else if (ic_req || dc_req) begin
`ifdef ARB_RR_EN
      m_own_d = (ic_req && dc_req) ? !m_last_d : dc_req;
`else
      m_own_d = dc_req;
`endif
      m_write = m_own_d && dc_we;
      m_addr  = m_own_d ? dc_addr : ic_addr;
      m_wdata = dc_wdata;
      m_busy  = 1'b1;
      m_age   = 0;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      logic        e_icg, e_dcg, e_en, e_wr, e_dv, e_done;
      logic [2:0]  e_word;
      logic [15:0] e_addr, e_data, e_wdata, base;
      e_icg = 0; e_dcg = 0; e_en = 0; e_wr = 0; e_dv = 0; e_done = 0;
      e_word = '0; e_addr = '0; e_data = '0; e_wdata = '0;
      base = {m_addr[15:4], 4'h0};
      if (m_busy) begin
        e_icg = !m_own_d;
        e_dcg = m_own_d;
        if (m_write) begin
          if (m_age == 0) begin
            e_en = 1; e_wr = 1; e_addr = m_addr; e_wdata = m_wdata;
          end else begin
            e_done = 1;
          end
        end else begin
          if (m_age < WPB) begin
            e_en = 1; e_addr = base + 16'(2 * m_age);
          end
          if (m_age >= MEM_LAT && m_age < MEM_LAT + WPB) begin
            e_dv = 1;
            e_word = 3'(m_age - MEM_LAT);
            e_data = base + 16'(2 * (m_age - MEM_LAT));
          end
          if (m_age == MEM_LAT + WPB) e_done = 1;
        end
      end
      check("ic_grant", ic_grant, e_icg);
      check("dc_grant", dc_grant, e_dcg);
      check("grant_exclusive", ic_grant & dc_grant, 0);
      check("ic_done", ic_done, e_done & !m_own_d);
      check("dc_done", dc_done, e_done & m_own_d);
      check("ic_data_valid", ic_data_valid, e_dv & !m_own_d);
      check("dc_data_valid", dc_data_valid, e_dv & m_own_d);
      check("mem_en", mem_en, e_en);
      check("mem_wr", mem_wr, e_wr);
      if (e_en || rst) check("mem_addr", mem_addr, e_addr);
      if ((e_en && e_wr) || rst) check("mem_wdata", mem_wdata, e_wdata);
      if (e_dv || rst) begin
        check("fill_word", fill_word, e_word);
        check("fill_data", fill_data, e_data);
      end
    end
  end

  typedef struct { int t; bit d; logic [2:0] word; logic [15:0] data; } fill_t;
  typedef struct { int t; logic wr; logic [15:0] addr; logic [15:0] wdata; } acc_t;
  fill_t fill_q[$];
  acc_t  acc_q[$];
  int    rv_count = 0;
  int    dv_count = 0;

  always @(negedge clk) begin
    if (ic_data_valid) fill_q.push_back('{cyc, 1'b0, fill_word, fill_data});
    if (dc_data_valid) fill_q.push_back('{cyc, 1'b1, fill_word, fill_data});
    if (mem_en) acc_q.push_back('{cyc, mem_wr, mem_addr, mem_wdata});
    if (mem_rvalid) rv_count++;
    if (ic_data_valid || dc_data_valid) dv_count++;
  end

  task automatic clear_logs();
    fill_q.delete();
    acc_q.delete();
  endtask

  task automatic at_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_any_done(output bit ok, output bit d, output int t);
    ok = 0; d = 0; t = -1;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (ic_done || dc_done) begin
        ok = 1; d = dc_done; t = cyc;
        break;
      end
    end
    check("done_seen", ok, 1);
  endtask

  task automatic check_fill(input string tag, input bit d, input logic [15:0] base, input int t0);
    check({tag, "_fill_count"}, fill_q.size(), WPB);
    if (fill_q.size() == WPB) begin
      check({tag, "_fill0_word"}, fill_q[0].word, 0);
      check({tag, "_fill0_data"}, fill_q[0].data, base);
      check({tag, "_fill0_cycle"}, fill_q[0].t, t0 + 5);
      check({tag, "_fill0_owner"}, fill_q[0].d, d);
      check({tag, "_fill7_word"}, fill_q[7].word, 7);
      check({tag, "_fill7_data"}, fill_q[7].data, base + 16'h000E);
      check({tag, "_fill7_cycle"}, fill_q[7].t, t0 + 12);
    end
  endtask

  initial begin
    bit ok, d;
    int t, t0;
    int rem_i, rem_d, rv0, dv0;
    bit order[$];
    int tdone[$];

    #1 rst = 1'b1;
    #1 checking = 1'b1;
    repeat (2) at_edge();
    check("reset_ic_grant", ic_grant, 0);
    check("reset_mem_en", mem_en, 0);
    check("reset_dc_done", dc_done, 0);
    rst = 1'b0;
    repeat (2) at_edge();

    // Back-to-back simultaneous pairs: both requesters want two fills each.
    clear_logs();
    t0 = cyc;
    ic_addr = 16'h2000; dc_addr = 16'h3008; dc_we = 1'b0;
    ic_req = 1'b1; dc_req = 1'b1;
    rem_i = 2; rem_d = 2;
    for (int k = 0; k < 4; k++) begin
      wait_any_done(ok, d, t);
      if (!ok) break;
      order.push_back(d);
      tdone.push_back(t);
      if (d) begin dc_req = 1'b0; rem_d--; end
      else   begin ic_req = 1'b0; rem_i--; end
      at_edge();
      if (d && rem_d > 0) dc_req = 1'b1;
      if (!d && rem_i > 0) ic_req = 1'b1;
    end
    check("pair_count", order.size(), 4);
    if (order.size() == 4) begin
`ifdef ARB_RR_EN
      check("order0", order[0], 1); check("order1", order[1], 0);
      check("order2", order[2], 1); check("order3", order[3], 0);
`else
      check("order0", order[0], 1); check("order1", order[1], 1);
      check("order2", order[2], 0); check("order3", order[3], 0);
`endif
      check("first_done_cycle", tdone[0], t0 + 13);
      check("second_done_gap", tdone[1] - tdone[0], 14);
    end
    at_edge();

    // I fill alone.
    clear_logs();
    t0 = cyc;
    ic_addr = 16'h1236; ic_req = 1'b1;
    wait_any_done(ok, d, t);
    ic_req = 1'b0;
    check("ifill_done_owner", d, 0);
    check("ifill_done_cycle", t, t0 + 13);
    at_edge();
    check_fill("ifill", 1'b0, 16'h1230, t0);
    check("ifill_issue_count", acc_q.size(), WPB);
    if (acc_q.size() == WPB) begin
      check("ifill_issue0_addr", acc_q[0].addr, 16'h1230);
      check("ifill_issue0_cycle", acc_q[0].t, t0 + 1);
      check("ifill_issue7_addr", acc_q[7].addr, 16'h123E);
      check("ifill_issue7_cycle", acc_q[7].t, t0 + 8);
    end

    // D write-through.
    clear_logs();
    at_edge();
    t0 = cyc;
    dc_addr = 16'h0040; dc_wdata = 16'hBEEF; dc_we = 1'b1; dc_req = 1'b1;
    wait_any_done(ok, d, t);
    dc_req = 1'b0; dc_we = 1'b0;
    check("dwrite_done_owner", d, 1);
    check("dwrite_done_cycle", t, t0 + 2);
    at_edge();
    check("dwrite_access_count", acc_q.size(), 1);
    if (acc_q.size() == 1) begin
      check("dwrite_wr", acc_q[0].wr, 1);
      check("dwrite_addr", acc_q[0].addr, 16'h0040);
      check("dwrite_wdata", acc_q[0].wdata, 16'hBEEF);
      check("dwrite_cycle", acc_q[0].t, t0 + 1);
    end

    // Request dropped during ISSUE still completes.
    clear_logs();
    at_edge();
    t0 = cyc;
    ic_addr = 16'h4444; ic_req = 1'b1;
    repeat (3) at_edge();
    ic_req = 1'b0;
    wait_any_done(ok, d, t);
    check("drop_done_owner", d, 0);
    check("drop_done_cycle", t, t0 + 13);
    at_edge();
    check_fill("drop", 1'b0, 16'h4440, t0);
    check("drop_issue_count", acc_q.size(), WPB);

    // Reset after the third return: 7 reads issued, 4 still in flight.
    clear_logs();
    at_edge();
    ic_addr = 16'h5550; ic_req = 1'b1;
    ok = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (ic_data_valid && fill_word == 3'd2) begin ok = 1; break; end
    end
    check("third_return_seen", ok, 1);
    at_edge();
    rst = 1'b1; ic_req = 1'b0;
    rv0 = rv_count; dv0 = dv_count;
    #1;
    check("midrst_ic_grant", ic_grant, 0);
    check("midrst_mem_en", mem_en, 0);
    check("midrst_ic_data_valid", ic_data_valid, 0);
    repeat (2) at_edge();
    rst = 1'b0;
    repeat (4) at_edge();
    check("stale_rvalid_pulses", rv_count - rv0, 4);
    check("stale_data_valid", dv_count - dv0, 0);

    clear_logs();
    t0 = cyc;
    ic_req = 1'b1;
    wait_any_done(ok, d, t);
    ic_req = 1'b0;
    check("postrst_done_cycle", t, t0 + 13);
    at_edge();
    check_fill("postrst", 1'b0, 16'h5550, t0);

    repeat (3) at_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one multi-cycle, pipelined main memory between the I-cache miss handler and the D-cache miss/write handler of the 16-bit pipelined cpu.
- Arbitrates between the two requesters and sequences 8-word block fills.
- Sequences single-word write-through stores.
- Drives per-word fill data back to the granted cache.

Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, memory word width
- WORDS_PER_BLK, 8, words per cache block (block = 16 bytes)
- MEM_LAT, 4, cycles from accepted read to mem_rvalid

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ic_req  in  1  I-cache fill request, held until ic_done
- ic_addr  in  ADDR_W  I-cache miss address; low 4 bits ignored
- ic_grant  out  1  I-cache owns memory
- ic_data_valid  out  1  fill_data holds an I-cache word this cycle
- ic_done  out  1  one-cycle pulse, I-cache transaction complete
- dc_req  in  1  D-cache request, held until dc_done
- dc_we  in  1  1 = single-word write, 0 = block fill
- dc_addr  in  ADDR_W  D-cache address (word address for writes)
- dc_wdata  in  DATA_W  write data
- dc_grant  out  1  D-cache owns memory
- dc_data_valid  out  1  fill_data holds a D-cache word this cycle
- dc_done  out  1  one-cycle pulse, D-cache transaction complete
- fill_word  out  3  word index of fill_data within the block
- fill_data  out  DATA_W  returned memory word
- mem_en  out  1  memory access this cycle
- mem_wr  out  1  write when mem_en
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  read data
- mem_rvalid  in  1  mem_rdata valid

Behaviour:
- Reset values:
  - All outputs are 0. State is IDLE.
  - Issue counter, return counter and owner register are cleared.
  - Reset mid-transaction aborts it. mem_rvalid pulses arriving after reset are ignored because they fall in IDLE.
- States:
  - IDLE
  - ISSUE: reads issued
  - DRAIN: waiting for remaining returns
  - WRITE
  - DONE
- IDLE:
  - Samples requests on each edge.
  - Default fixed priority: dc_req beats ic_req, because the MEM stage is older than IF.
  - Winner is latched in the owner register. Request address is latched; wdata is latched for writes.
  - Fill → ISSUE; D write → WRITE.
  - No request → stay in IDLE.
- Grant:
  - The owner's grant is 1 from the first cycle after the winning edge through the DONE cycle inclusive.
  - The other grant stays 0.
- ISSUE:
  - Lasts exactly WORDS_PER_BLK cycles.
  - Each cycle: mem_en=1, mem_wr=0, mem_addr = {addr[15:4],4'b0} + 2*issue_cnt, with issue_cnt running 0..7.
  - Exits to DRAIN after issue_cnt=7.
- Returns:
  - Counted in ISSUE and DRAIN.
  - On each mem_rvalid: fill_data=mem_rdata, fill_word=ret_cnt, and the owner's data_valid=1 in that same cycle (combinational from mem_rvalid). ret_cnt then increments.
  - Returns are assumed in order.
  - mem_rvalid in IDLE, WRITE or DONE, or beyond 8 returns, is ignored.
- Leaving DRAIN: on the edge where the 8th return is taken, go to DONE.
- WRITE:
  - One cycle: mem_en=1, mem_wr=1, mem_addr=latched dc_addr, mem_wdata=latched wdata.
  - Then → DONE.
- DONE:
  - Owner's done=1 for exactly one cycle, then → IDLE.
  - New arbitration starts in IDLE on the following edge, so at least one idle cycle separates transactions.
- Request drop: deassertion of a req mid-transaction does not abort. The transaction completes, and done still pulses.
- mem_* outputs: decoded from state and counter registers only. There is no combinational path from ic_req or dc_req.
- Fill timing, MEM_LAT=4, request sampled at edge 0:
  - grant and first issue at cycle 1.
  - Returns at cycles 5–12.
  - done at cycle 13.
  - IDLE at cycle 14.

Optional Feature:
- ARB_RR_EN defined:
  - Round-robin replaces fixed priority.
  - A last_owner register is updated on each DONE and reset to I-cache, so D wins the first simultaneous tie.
  - On a simultaneous request, the requester that was not last served wins.
  - A lone requester always wins.
- ARB_RR_EN undefined: fixed D-over-I priority. I-cache starvation is accepted.

Test Plan:
- I fill alone: ic_req=1, ic_addr=0x1236, MEM_LAT=4, memory returns word = address.
  - mem_addr = 0x1230..0x123E in cycles 1–8.
  - ic_data_valid in cycles 5–12 with fill_word 0..7 and data 0x1230..0x123E.
  - ic_done at cycle 13; dc_grant stays 0 throughout.
- D write: dc_req=1, dc_we=1, dc_addr=0x0040, dc_wdata=0xBEEF.
  - One cycle mem_en=1, mem_wr=1, addr 0x0040, wdata 0xBEEF.
  - dc_done the next cycle.
- Simultaneous: ic_req and dc_req (fill) raised on the same edge.
  - D fill completes first.
  - One idle cycle, then I fill grants.
  - Grants are never both 1.
- Reset mid-fill: assert rst after the 3rd return.
  - All outputs 0 immediately.
  - Later mem_rvalid pulses produce no data_valid.
  - A new ic_req after reset gets a full 8-word fill from word 0.
- Request drop: ic_req dropped during ISSUE → all 8 issues and returns still occur, and ic_done pulses.
- ARB_RR_EN: two back-to-back simultaneous request pairs → D served, then I, then D, then I. Without the macro: D, D, then I.
